// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: IR fields and memory handshake in, datapath control lines out.
interface micro_sequencer_if #(parameter int UPC_W = 4);
  logic [5:0] OP_Code;
  logic [5:0] Func;
  logic mem_ready;
  logic pc_wr;
  logic pc_wr_cond;
  logic [1:0] pc_src;
  logic ir_wr;
  logic mem_rd;
  logic mem_wr;
  logic i_or_d;
  logic reg_wr;
  logic reg_dst;
  logic mem_to_reg;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [UPC_W-1:0] upc;
  logic inst_done;
  logic trap;
  modport master (
    input OP_Code, Func, mem_ready,
    output pc_wr, pc_wr_cond, pc_src, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, upc, inst_done, trap
  );
  modport slave (
    output OP_Code, Func, mem_ready,
    input pc_wr, pc_wr_cond, pc_src, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst,
          mem_to_reg, alu_src_a, alu_src_b, alu_op, upc, inst_done, trap
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control unit for the multi-cycle MIPS datapath.
module micro_sequencer #(parameter int UPC_W = 4) (
  input logic clk,
  input logic rst_n,
  micro_sequencer_if.master bus
);
  localparam logic [UPC_W-1:0] S_FETCH = UPC_W'(0);
  localparam logic [UPC_W-1:0] S_DECODE = UPC_W'(1);
  localparam logic [UPC_W-1:0] S_MEM_ADDR = UPC_W'(2);
  localparam logic [UPC_W-1:0] S_MEM_READ = UPC_W'(3);
  localparam logic [UPC_W-1:0] S_LW_WB = UPC_W'(4);
  localparam logic [UPC_W-1:0] S_MEM_WRITE = UPC_W'(5);
  localparam logic [UPC_W-1:0] S_R_EXEC = UPC_W'(6);
  localparam logic [UPC_W-1:0] S_R_WB = UPC_W'(7);
  localparam logic [UPC_W-1:0] S_BEQ = UPC_W'(8);
  localparam logic [UPC_W-1:0] S_JUMP = UPC_W'(9);
  localparam logic [UPC_W-1:0] S_ADDI_EXEC = UPC_W'(10);
  localparam logic [UPC_W-1:0] S_I_WB = UPC_W'(11);
  localparam logic [UPC_W-1:0] S_TRAP = UPC_W'(12);
  logic [UPC_W-1:0] r_upc;
  logic [UPC_W-1:0] w_nxt;
  logic [UPC_W-1:0] w_disp1;
  logic [2:0] r_alu_fn;
  logic [2:0] w_alu_fn;
  logic r_is_sw;
  logic r_trap;
  logic w_func_ok;
  logic [11:0] w_s;
  // IR fields are only valid in DECODE, so the R-type op and the lw/sw choice are captured there
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upc <= S_FETCH;
      r_trap <= 1'b0;
      r_alu_fn <= 3'd0;
      r_is_sw <= 1'b0;
    end else begin
      r_upc <= w_nxt;
      r_trap <= r_trap | (w_nxt == S_TRAP);
      if (r_upc == S_DECODE) begin
        r_alu_fn <= w_alu_fn;
        r_is_sw <= bus.OP_Code == 6'h2b;
      end
    end
  end
  always_comb begin
    w_alu_fn = 3'd0;
    w_func_ok = 1'b1;
    case (bus.Func)
      6'h21: w_alu_fn = 3'd0;
      6'h23: w_alu_fn = 3'd1;
      6'h24: w_alu_fn = 3'd2;
      6'h25: w_alu_fn = 3'd3;
      6'h2a: w_alu_fn = 3'd4;
      default: w_func_ok = 1'b0;
    endcase
    case (bus.OP_Code)
      6'h00: w_disp1 = w_func_ok ? S_R_EXEC : S_TRAP;
      6'h23, 6'h2b: w_disp1 = S_MEM_ADDR;
      6'h04: w_disp1 = S_BEQ;
      6'h02: w_disp1 = S_JUMP;
      6'h09: w_disp1 = S_ADDI_EXEC;
      default: w_disp1 = S_TRAP;
    endcase
    case (r_upc)
      S_FETCH: w_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_nxt = w_disp1;
      S_MEM_ADDR: w_nxt = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: w_nxt = bus.mem_ready ? S_LW_WB : S_MEM_READ;
      S_MEM_WRITE: w_nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC: w_nxt = S_R_WB;
      S_ADDI_EXEC: w_nxt = S_I_WB;
      S_LW_WB, S_R_WB, S_BEQ, S_JUMP, S_I_WB: w_nxt = S_FETCH;
      default: w_nxt = S_TRAP;
    endcase
  end
  // one-hot view of the live state; empty while in reset or TRAP, which silences every control
  always_comb begin
    w_s = rst_n ? (12'd1 << r_upc) : 12'd0;
    bus.ir_wr = w_s[0] & bus.mem_ready;
    bus.pc_wr = (w_s[0] & bus.mem_ready) | w_s[9];
    bus.pc_wr_cond = w_s[8];
    bus.pc_src = w_s[9] ? 2'd2 : w_s[8] ? 2'd1 : 2'd0;
    bus.mem_rd = w_s[0] | w_s[3];
    bus.mem_wr = w_s[5];
    bus.i_or_d = w_s[3] | w_s[5];
    bus.reg_wr = w_s[4] | w_s[7] | w_s[11];
    bus.reg_dst = w_s[7];
    bus.mem_to_reg = w_s[4];
    bus.alu_src_a = w_s[2] | w_s[6] | w_s[8] | w_s[10];
    bus.alu_src_b = w_s[0] ? 2'd1 : w_s[1] ? 2'd3 : (w_s[2] | w_s[10]) ? 2'd2 : 2'd0;
    bus.alu_op = w_s[6] ? r_alu_fn : w_s[8] ? 3'd1 : 3'd0;
    bus.inst_done = w_s[4] | w_s[7] | w_s[8] | w_s[9] | w_s[11] | (w_s[5] & bus.mem_ready);
    bus.upc = r_upc;
    bus.trap = r_trap;
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: random instruction stream checked against a path-based model of the micro-program.
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [17:0] got_ctl;
  micro_sequencer_if #(.UPC_W(4)) bus();
  micro_sequencer #(.UPC_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got_ctl = {bus.pc_wr, bus.pc_wr_cond, bus.pc_src, bus.ir_wr, bus.mem_rd, bus.mem_wr,
                    bus.i_or_d, bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.inst_done};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [17:0] ctl(input int s, input bit mr, input logic [2:0] rop);
    logic pw = 0, pwc = 0, iw = 0, mrd = 0, mwr = 0, iod = 0, rw = 0, rd = 0, m2r = 0, sa = 0, dn = 0;
    logic [1:0] ps = 0, sb = 0;
    logic [2:0] op = 0;
    case (s)
      0: begin mrd = 1; sb = 1; iw = mr; pw = mr; end
      1: sb = 3;
      2: begin sa = 1; sb = 2; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mwr = 1; iod = 1; dn = mr; end
      6: begin sa = 1; op = rop; end
      7: begin rw = 1; rd = 1; dn = 1; end
      8: begin sa = 1; op = 1; pwc = 1; ps = 1; dn = 1; end
      9: begin pw = 1; ps = 2; dn = 1; end
      10: begin sa = 1; sb = 2; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, iw, mrd, mwr, iod, rw, rd, m2r, sa, sb, op, dn};
  endfunction
  task automatic do_reset(input int n, input bit mr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.mem_ready = mr;
      bus.OP_Code = 6'($urandom);
      bus.Func = 6'($urandom);
      #1;
      chk("rst_ctl", 32'(got_ctl), 0);
      if (i > 0) begin
        chk("rst_upc", 32'(bus.upc), 0);
        chk("rst_trap", 32'(bus.trap), 0);
      end
    end
  endtask
  task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input int ss, input int sn,
                          input bit rnd, input int abort);
    int path[$];
    int pos = 0, cyc = 0, stalls = 0, held = 0, ndone = 0, s;
    bit mr, r_ok;
    logic [2:0] rop;
    r_ok = 1;
    case (fn)
      6'h21: rop = 0;
      6'h23: rop = 1;
      6'h24: rop = 2;
      6'h25: rop = 3;
      6'h2a: rop = 4;
      default: begin rop = 0; r_ok = 0; end
    endcase
    case (op)
      6'h00: path = r_ok ? '{0, 1, 6, 7} : '{0, 1, 12};
      6'h23: path = '{0, 1, 2, 3, 4};
      6'h2b: path = '{0, 1, 2, 5};
      6'h04: path = '{0, 1, 8};
      6'h02: path = '{0, 1, 9};
      6'h09: path = '{0, 1, 10, 11};
      default: path = '{0, 1, 12};
    endcase
    while (pos < path.size()) begin
      @(negedge clk);
      rst_n = 1'b1;
      s = path[pos];
      mr = (s == ss && held < sn) ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s == ss && held < sn) held++;
      bus.mem_ready = mr;
      bus.OP_Code = (s == 1) ? op : 6'($urandom);
      bus.Func = (s == 1) ? fn : 6'($urandom);
      #1;
      chk("upc", 32'(bus.upc), 32'(s));
      chk("ctl", 32'(got_ctl), 32'(ctl(s, mr, rop)));
      chk("trap", 32'(bus.trap), 32'(s == 12));
      ndone += int'(bus.inst_done);
      cyc++;
      if (cyc == abort) return;
      if (s == 12) begin
        if (cyc >= 8) return;
      end else if ((s == 0 || s == 3 || s == 5) && !mr) stalls++;
      else pos++;
      if (cyc > 300) begin
        chk("timeout", 32'(cyc), 300);
        return;
      end
    end
    chk("latency", 32'(cyc), 32'(path.size() + stalls));
    chk("done_cnt", 32'(ndone), 1);
  endtask
  initial begin
    logic [5:0] ops [6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h09};
    logic [5:0] fns [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};
    logic [5:0] op, fn;
    bus.mem_ready = 1'b1;
    bus.OP_Code = 6'h0;
    bus.Func = 6'h0;
    do_reset(3, 1'b1);
    run_inst(6'h23, 6'h00, -1, 0, 1'b0, -1);
    run_inst(6'h00, 6'h23, -1, 0, 1'b0, -1);
    run_inst(6'h2b, 6'h00, 5, 2, 1'b0, -1);
    run_inst(6'h02, 6'h00, 0, 4, 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_inst(op, fn, -1, 0, 1'b1, -1);
    end
    run_inst(6'h2b, 6'h00, 5, 100, 1'b0, 6);
    do_reset(2, 1'b0);
    run_inst(6'h23, 6'h00, -1, 0, 1'b1, -1);
    run_inst(6'h3f, 6'h00, -1, 0, 1'b1, -1);
    do_reset(2, 1'b1);
    run_inst(6'h00, 6'h08, -1, 0, 1'b1, -1);
    do_reset(2, 1'b1);
    run_inst(6'h09, 6'h00, -1, 0, 1'b1, -1);
    run_inst(6'h04, 6'h00, -1, 0, 1'b1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogrammed control unit for the multi-cycle MIPS datapath. Sits directly downstream of the instruction register: consumes the decoded `OP_Code` and `Func` fields and drives every datapath control line, including the IR write strobe that loads the next instruction. A 4-bit micro-PC steps through a fixed microinstruction ROM, with two dispatch tables and a memory-ready handshake that stalls memory micro-steps.

## Interface
Parameters:
- `UPC_W`, default 4: micro-PC width (13 micro-addresses used).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `OP_Code`  input  6  opcode from the IR; valid from the cycle after `ir_wr`.
- `Func`  input  6  R-type function field from the IR; same validity as `OP_Code`.
- `mem_ready`  input  1  memory handshake; the access completes in a cycle where it is 1.
- `pc_wr`  output  1  unconditional PC write.
- `pc_wr_cond`  output  1  PC write when ALU zero (beq).
- `pc_src`  output  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- `ir_wr`  output  1  IR load strobe (the IR `W` input).
- `mem_rd`  output  1  memory read request.
- `mem_wr`  output  1  memory write request.
- `i_or_d`  output  1  0 = PC address, 1 = ALUOut address.
- `reg_wr`  output  1  register file write.
- `reg_dst`  output  1  0 = Rt, 1 = Rd.
- `mem_to_reg`  output  1  0 = ALUOut, 1 = MDR.
- `alu_src_a`  output  1  0 = PC, 1 = A register.
- `alu_src_b`  output  2  0 = B, 1 = const 4, 2 = sext imm16, 3 = sext imm16 << 2.
- `alu_op`  output  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
- `upc`  output  UPC_W  current micro-address (debug).
- `inst_done`  output  1  one-cycle pulse on the final micro-step of each instruction.
- `trap`  output  1  unsupported opcode/func seen; sticky.

## Operation
- Micro-addresses, with the asserted controls and the next address:
  - 0 FETCH: mem_rd, i_or_d=0, src_a=0, src_b=1, op add. `ir_wr` and `pc_wr` are gated by `mem_ready`. Goes to 1 when `mem_ready`=1, else stays at 0.
  - 1 DECODE: src_a=0, src_b=3, op add (branch target). Next address from dispatch 1.
  - 2 MEM_ADDR: src_a=1, src_b=2, op add. Next address from dispatch 2: lw → 3, sw → 5.
  - 3 MEM_READ: mem_rd, i_or_d=1. Goes to 4 when `mem_ready`=1, else holds.
  - 4 LW_WB: reg_wr, reg_dst=0, mem_to_reg=1. Goes to 0.
  - 5 MEM_WRITE: mem_wr, i_or_d=1. Goes to 0 when `mem_ready`=1, else holds.
  - 6 R_EXEC: src_a=1, src_b=0, op from Func. Goes to 7.
  - 7 R_WB: reg_wr, reg_dst=1, mem_to_reg=0. Goes to 0.
  - 8 BEQ: src_a=1, src_b=0, op sub, pc_wr_cond, pc_src=1. Goes to 0.
  - 9 JUMP: pc_wr, pc_src=2. Goes to 0.
  - 10 ADDI_EXEC: src_a=1, src_b=2, op add. Goes to 11.
  - 11 I_WB: reg_wr, reg_dst=0, mem_to_reg=0. Goes to 0.
  - 12 TRAP: no controls asserted. Holds until reset.
- Dispatch 1 on `OP_Code`: 0x00 → 6, 0x23 → 2, 0x2B → 2, 0x04 → 8, 0x02 → 9, 0x09 → 10, anything else → 12.
- R-type `Func` decode, applied at DECODE:
  - 0x21 → add, 0x23 → sub, 0x24 → and, 0x25 → or, 0x2A → slt.
  - Any other Func sends DECODE to 12 instead of 6.
- Controls not listed for a state are 0.
- All outputs are a combinational decode of `upc` plus the `mem_ready` gating.
- `inst_done` = 1 in states 4, 7, 8, 9 and 11 unconditionally, and in state 5 only when `mem_ready`=1.
- `trap` is set on entry to 12 and cleared only by reset.

## Timing
- Reset: `rst_n` low at a rising edge → `upc`=0 and `trap`=0.
- While `rst_n` is low, every write/request output is forced to 0: pc_wr, pc_wr_cond, ir_wr, mem_rd, mem_wr, reg_wr, inst_done. Mux selects read 0.
- Reset wins over any in-flight micro-step, including a stalled MEM_WRITE. No partial write is issued afterwards.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles; sw: 4; R-type: 4; addiu: 4; beq: 3; j: 3.
- Each stall cycle (`mem_ready`=0 in 0, 3 or 5) adds one cycle. Controls hold steady during a stall. `ir_wr`/`pc_wr` never pulse until `mem_ready`=1.
- `OP_Code`/`Func` are sampled only in DECODE. Their values in any other state are ignored.
- `mem_ready` is ignored outside states 0, 3 and 5.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → `upc`=0, all strobes 0, `trap`=0. First cycle after release: mem_rd=1, ir_wr=1, pc_wr=1.
- lw (OP 0x23), `mem_ready`=1 → upc sequence 0, 1, 2, 3, 4, 0. reg_wr=1 with mem_to_reg=1 only in state 4. `inst_done` pulses once.
- R-type subu (OP 0x00, Func 0x23) → upc 0, 1, 6, 7, 0. alu_op=1 in state 6. reg_dst=1 and reg_wr=1 in state 7.
- sw with `mem_ready` low for 2 cycles in MEM_WRITE → mem_wr held 3 cycles. Total 6 cycles. `inst_done` only in the last cycle.
- FETCH stall: `mem_ready`=0 for 4 cycles → upc stays 0, ir_wr=0, pc_wr=0. Both pulse exactly once when `mem_ready` rises.
- OP 0x3F, or OP 0x00 with Func 0x08 → upc 12, `trap`=1, all strobes 0 indefinitely. `rst_n` pulse → `trap`=0, upc=0.
